word2bit_trans_pp: RTL and testbench
====================================

WORD2BIT_TRANS_PP -- requirements
Module: word2bit_trans_pp

Interface
REQ-001 SHALL have parameter MAX_CHANNEL_NUM, default 128: max channels per packet (bit-plane width).
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per input word (planes per packet).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk_i  in  1  clock
- rst_i  in  1  sync active-high reset
- wordser_data_i  in  DATA_WIDTH  word-serial channel word
- wordser_data_vld_i  in  1  input valid
- wordser_data_rdy_o  out  1  input ready
- channel_num_i  in  clog2(MAX_CHANNEL_NUM)  index of last channel in packet
- msb_first_i  in  1  plane order: 1 = MSB plane first
- flush_i  in  1  sync abort, discards all packets
- bitpar_data_o  out  MAX_CHANNEL_NUM  one bit-plane, bit i = channel i
- bitpar_data_vld_o  out  1  plane valid
- bitpar_data_rdy_i  in  1  plane ready
- bitpar_bit_idx_o  out  clog2(DATA_WIDTH)  bit index of current plane
- bitpar_last_o  out  1  current plane is last of packet
- packet_received_o  out  1  one-cycle pulse, packet fully drained

Function
REQ-005 SHALL accept a word when wordser_data_vld_i && wordser_data_rdy_o, storing it at channel wr_cnt of write bank.
REQ-006 SHALL latch channel_num_i and msb_first_i per bank on the first accepted word of a packet; later changes ignored until next packet.
REQ-007 SHALL increment wr_cnt per accept; on accept at wr_cnt == latched channel_num: mark bank full, wr_cnt -> 0, toggle write bank.
REQ-008 SHALL drive wordser_data_rdy_o = !full[write bank], from registers only (no comb path from bitpar_data_rdy_i).
REQ-009 SHALL drive bitpar_data_vld_o = full[read bank]; first plane valid the cycle after the last word is accepted.
REQ-010 SHALL advance plane counter rd_cnt 0..DATA_WIDTH-1 per fire (vld && rdy); hold outputs stable while vld && !rdy.
REQ-011 SHALL output plane bit b = rd_cnt (LSB-first) or DATA_WIDTH-1-rd_cnt (MSB-first); bitpar_bit_idx_o = b.
REQ-012 SHALL force bitpar_data_o[i] = 0 for i > latched channel_num of the read bank.
REQ-013 SHALL assert bitpar_last_o when rd_cnt == DATA_WIDTH-1 and vld.
REQ-014 SHALL on fire of last plane: clear full[read bank], rd_cnt -> 0, toggle read bank, pulse packet_received_o next cycle.
REQ-015 SHALL let a bank freed in cycle N accept a write no earlier than N+1.
REQ-016 SHALL allow packet completion on write bank and drain of read bank in the same cycle, both taking effect.
REQ-017 SHALL support channel_num_i = 0 (one-word packet) and MAX_CHANNEL_NUM-1 (full bank).
REQ-018 SHALL on flush_i: clear full flags, counters, bank pointers, vld, packet_received_o next cycle; data accepted on a flush cycle is dropped.

Reset
REQ-019 SHALL on rst_i reset: wordser_data_rdy_o=1, bitpar_data_vld_o=0, bitpar_last_o=0, bitpar_bit_idx_o=0 (LSB-first default), bitpar_data_o=0, packet_received_o=0.
REQ-020 SHALL not reset bank storage; masking (REQ-012) and full flags guarantee no stale data is emitted.

Configuration
REQ-021 SHALL with WORD2BIT_PINGPONG_EN defined instantiate two banks; fill of one overlaps drain of other.
REQ-022 SHALL without WORD2BIT_PINGPONG_EN instantiate one bank; rdy low from packet completion until last plane fires; bank pointers tied to 0.

Structure
REQ-023 SHALL place in shared package word2bit_pkg: default MAX_CHANNEL_NUM/DATA_WIDTH constants, CH_W/BIT_W width functions, bank-count constant.
REQ-024 SHALL use sub-module word2bit_bank: one storage bank, write port, latched config, masked bit-plane read mux.

Verification
REQ-025 Reset, no stimulus -> rdy=1, vld=0, packet_received_o never pulses.
REQ-026 channel_num=3, words 0x01,0x02,0x04,0x80, LSB-first, rdy=1 -> planes 0x1,0x2,0x4,0,0,0,0,0x8, idx 0..7, last on 8th, pulse 1 cycle later.
REQ-027 Same packet MSB-first, bitpar_data_rdy_i toggling 1/0 -> planes reversed (0x8 first), idx 7..0, held stable during stalls.
REQ-028 PINGPONG_EN, two back-to-back 128-word packets, rdy=1 -> input never stalls during first drain; 16 planes, two pulses.
REQ-029 Without PINGPONG_EN, same -> rdy low from 128th accept until 8th plane fires; second packet intact.
REQ-030 flush_i mid-drain (plane 3) with other bank full -> vld=0 next cycle, no pulse, next packet channel_num=0 word 0xFF -> eight planes 0x1.

Source files
------------

// File: rtl/word2bit_pkg.sv
// rtl/word2bit_pkg.sv - shared constants and width helpers; bank count set by WORD2BIT_PINGPONG_EN
package word2bit_pkg;

    localparam int DEF_MAX_CHANNEL_NUM = 128;
    localparam int DEF_DATA_WIDTH      = 8;

`ifdef WORD2BIT_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    function automatic int ch_w(input int max_channel_num);
        return (max_channel_num > 1) ? $clog2(max_channel_num) : 1;
    endfunction

    function automatic int bit_w(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/word2bit_bank.sv
// rtl/word2bit_bank.sv - one word storage bank with latched packet config and masked bit-plane read
module word2bit_bank
    import word2bit_pkg::*;
#(
    parameter  int MAX_CHANNEL_NUM = DEF_MAX_CHANNEL_NUM,
    parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
    localparam int CH_W            = ch_w(MAX_CHANNEL_NUM),
    localparam int BIT_W           = bit_w(DATA_WIDTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic                       cfg_en_i,
    input  logic [CH_W-1:0]            wr_addr_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    input  logic [CH_W-1:0]            channel_num_i,
    input  logic                       msb_first_i,
    input  logic [BIT_W-1:0]           rd_cnt_i,
    output logic [CH_W-1:0]            channel_num_o,
    output logic [BIT_W-1:0]           bit_idx_o,
    output logic [MAX_CHANNEL_NUM-1:0] plane_o
);

    logic [DATA_WIDTH-1:0] mem_q [MAX_CHANNEL_NUM];
    logic [CH_W-1:0]       chn_q;
    logic                  msb_q;

    // Storage is never reset; channels above chn_q are masked on read.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            chn_q <= '0;
            msb_q <= 1'b0;
        end else if (cfg_en_i) begin
            chn_q <= channel_num_i;
            msb_q <= msb_first_i;
        end
    end

    assign channel_num_o = chn_q;
    assign bit_idx_o     = msb_q ? (BIT_W'(DATA_WIDTH - 1) - rd_cnt_i) : rd_cnt_i;

    always_comb begin
        plane_o = '0;
        for (int i = 0; i < MAX_CHANNEL_NUM; i++) begin
            if (CH_W'(i) <= chn_q) begin
                plane_o[i] = mem_q[i][bit_idx_o];
            end
        end
    end

endmodule

// File: rtl/word2bit_trans_pp.sv
// rtl/word2bit_trans_pp.sv - word-serial to bit-plane transposer; WORD2BIT_PINGPONG_EN selects two banks
module word2bit_trans_pp
    import word2bit_pkg::*;
#(
    parameter  int MAX_CHANNEL_NUM = DEF_MAX_CHANNEL_NUM,
    parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
    localparam int CH_W            = ch_w(MAX_CHANNEL_NUM),
    localparam int BIT_W           = bit_w(DATA_WIDTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_WIDTH-1:0]      wordser_data_i,
    input  logic                       wordser_data_vld_i,
    output logic                       wordser_data_rdy_o,
    input  logic [CH_W-1:0]            channel_num_i,
    input  logic                       msb_first_i,
    input  logic                       flush_i,
    output logic [MAX_CHANNEL_NUM-1:0] bitpar_data_o,
    output logic                       bitpar_data_vld_o,
    input  logic                       bitpar_data_rdy_i,
    output logic [BIT_W-1:0]           bitpar_bit_idx_o,
    output logic                       bitpar_last_o,
    output logic                       packet_received_o
);

    logic [1:0]                 full_q;
    logic [1:0]                 full_d;
    logic                       wr_bank_q;
    logic                       rd_bank_q;
    logic [CH_W-1:0]            wr_cnt_q;
    logic [BIT_W-1:0]           rd_cnt_q;
    logic                       pkt_rcv_q;
    logic [CH_W-1:0]            bank_chn   [2];
    logic [BIT_W-1:0]           bank_idx   [2];
    logic [MAX_CHANNEL_NUM-1:0] bank_plane [2];
    logic                       accept;
    logic                       first_word;
    logic                       wr_last;
    logic                       fire;
    logic                       rd_last;

    assign wordser_data_rdy_o = !full_q[wr_bank_q];
    assign bitpar_data_vld_o  = full_q[rd_bank_q];

    assign accept     = wordser_data_vld_i && wordser_data_rdy_o && !flush_i;
    assign first_word = (wr_cnt_q == '0);
    // The first word of a packet is compared against the live channel count, later words against the latched one.
    assign wr_last    = accept && (first_word ? (channel_num_i == '0)
                                              : (wr_cnt_q == bank_chn[wr_bank_q]));
    assign fire       = bitpar_data_vld_o && bitpar_data_rdy_i;
    assign rd_last    = fire && (rd_cnt_q == BIT_W'(DATA_WIDTH - 1));

    always_comb begin
        full_d = full_q;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            full_q    <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            pkt_rcv_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_last) begin
                wr_cnt_q <= '0;
            end else if (accept) begin
                wr_cnt_q <= wr_cnt_q + CH_W'(1);
            end
            if (rd_last) begin
                rd_cnt_q <= '0;
            end else if (fire) begin
                rd_cnt_q <= rd_cnt_q + BIT_W'(1);
            end
            pkt_rcv_q <= rd_last;
        end
    end

`ifdef WORD2BIT_PINGPONG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            if (wr_last) wr_bank_q <= !wr_bank_q;
            if (rd_last) rd_bank_q <= !rd_bank_q;
        end
    end
`else
    assign wr_bank_q = 1'b0;
    assign rd_bank_q = 1'b0;
`endif

    for (genvar g = 0; g < 2; g++) begin : g_bank
        if (g < NUM_BANKS) begin : g_inst
            word2bit_bank #(
                .MAX_CHANNEL_NUM (MAX_CHANNEL_NUM),
                .DATA_WIDTH      (DATA_WIDTH)
            ) u_bank (
                .clk_i         (clk_i),
                .rst_i         (rst_i),
                .wr_en_i       (accept && (wr_bank_q == 1'(g))),
                .cfg_en_i      (accept && first_word && (wr_bank_q == 1'(g))),
                .wr_addr_i     (wr_cnt_q),
                .wr_data_i     (wordser_data_i),
                .channel_num_i (channel_num_i),
                .msb_first_i   (msb_first_i),
                .rd_cnt_i      (rd_cnt_q),
                .channel_num_o (bank_chn[g]),
                .bit_idx_o     (bank_idx[g]),
                .plane_o       (bank_plane[g])
            );
        end else begin : g_tie
            assign bank_chn[g]   = '0;
            assign bank_idx[g]   = '0;
            assign bank_plane[g] = '0;
        end
    end

    assign bitpar_data_o     = bitpar_data_vld_o ? bank_plane[rd_bank_q] : '0;
    assign bitpar_bit_idx_o  = bank_idx[rd_bank_q];
    assign bitpar_last_o     = bitpar_data_vld_o && (rd_cnt_q == BIT_W'(DATA_WIDTH - 1));
    assign packet_received_o = pkt_rcv_q;

endmodule

// File: tb/tb_word2bit_trans_pp.sv
// tb/tb_word2bit_trans_pp.sv - randomized self-checking bench for word2bit_trans_pp
`timescale 1ns/1ps
module tb_word2bit_trans_pp;

    localparam int MAXC = 128;
    localparam int DW   = 8;
    typedef logic [MAXC-1:0][DW-1:0] words_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   wd;
    logic            wv;
    logic            wr_o;
    logic [6:0]      chn_i;
    logic            msb_i;
    logic            flush;
    logic [MAXC-1:0] bd;
    logic            bv;
    logic            br;
    logic [2:0]      bidx;
    logic            blast;
    logic            prcv;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int stall_err, spurious, in_stalls;
    bit timed_out;

    logic [MAXC-1:0] obs_data  [$];
    logic [2:0]      obs_idx   [$];
    logic            obs_last  [$];
    logic            obs_pulse [$];
    words_t          exp_w     [$];
    int              exp_chn   [$];
    bit              exp_msb   [$];

    always #5 clk = ~clk;

    word2bit_trans_pp dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .wordser_data_i     (wd),
        .wordser_data_vld_i (wv),
        .wordser_data_rdy_o (wr_o),
        .channel_num_i      (chn_i),
        .msb_first_i        (msb_i),
        .flush_i            (flush),
        .bitpar_data_o      (bd),
        .bitpar_data_vld_o  (bv),
        .bitpar_data_rdy_i  (br),
        .bitpar_bit_idx_o   (bidx),
        .bitpar_last_o      (blast),
        .packet_received_o  (prcv)
    );

    always @(negedge clk) begin
        if (rst === 1'b0 && prcv === 1'b1) pulse_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    // Plane k of a packet: bit i is bit b of word i, b counted from the chosen end, channels past chn are zero.
    function automatic logic [MAXC-1:0] model_plane(input words_t w, input int chn, input bit msb, input int k);
        logic [MAXC-1:0] r;
        int b;
        r = '0;
        b = msb ? (DW - 1 - k) : k;
        for (int i = 0; i <= chn; i++) r[i] = w[i][b];
        return r;
    endfunction

    function automatic words_t rand_words();
        words_t w;
        for (int i = 0; i < MAXC; i++) w[i] = DW'($urandom);
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wv = 1'b0; wd = '0; chn_i = '0; msb_i = 1'b0; flush = 1'b0; br = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        obs_data.delete(); obs_idx.delete(); obs_last.delete(); obs_pulse.delete();
        exp_w.delete(); exp_chn.delete(); exp_msb.delete();
        stall_err = 0; spurious = 0; in_stalls = 0; timed_out = 1'b0;
    endtask

    // Offers words 0..chn; returns on the negedge just before the last word is accepted.
    task automatic send_packet(input words_t w, input int chn, input bit msb, input bit scramble);
        int cyc;
        for (int i = 0; i <= chn; i++) begin
            @(negedge clk);
            wv = 1'b1;
            wd = w[i];
            if (i == 0 || !scramble) begin
                chn_i = 7'(chn);
                msb_i = msb;
            end else begin
                chn_i = 7'($urandom);
                msb_i = 1'($urandom);
            end
            cyc = 0;
            while (!wr_o) begin
                in_stalls++;
                @(negedge clk);
                cyc++;
                if (cyc > 2000) begin
                    timed_out = 1'b1;
                    break;
                end
            end
            if (timed_out) break;
        end
    endtask

    // Records fired planes, the pulse right after each last plane, and hold violations during stalls.
    task automatic collect(input int n, input int mode);
        logic [MAXC-1:0] held_d;
        logic [2:0]      held_i;
        bit              held_v;
        bit              pend_last;
        int              got;
        int              cyc;
        held_v = 1'b0; pend_last = 1'b0; got = 0; cyc = 0;
        held_d = '0; held_i = '0;
        while ((got < n || pend_last) && !timed_out) begin
            @(negedge clk);
            cyc++;
            if (pend_last) begin
                obs_pulse.push_back(prcv);
                pend_last = 1'b0;
            end else if (prcv !== 1'b0) begin
                spurious++;
            end
            if (held_v && (bd !== held_d || bidx !== held_i || bv !== 1'b1)) stall_err++;
            if (got < n) begin
                case (mode)
                    0:       br = 1'b1;
                    1:       br = cyc[0];
                    default: br = 1'($urandom);
                endcase
            end else begin
                br = 1'b0;
            end
            held_v = bv && !br;
            held_d = bd;
            held_i = bidx;
            if (bv && br) begin
                obs_data.push_back(bd);
                obs_idx.push_back(bidx);
                obs_last.push_back(blast);
                got++;
                if (blast) pend_last = 1'b1;
            end
            if (cyc > 8000) timed_out = 1'b1;
        end
        br = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_vec++; if (wr_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy c=%0d got %b want 1", c, wr_o); end
            n_vec++; if (bv !== 1'b0)   begin n_err++; $display("FAIL reset_vld c=%0d got %b want 0", c, bv); end
            n_vec++; if (prcv !== 1'b0) begin n_err++; $display("FAIL reset_pulse c=%0d got %b want 0", c, prcv); end
            if (c == 0) begin
                n_vec++; if (blast !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", blast); end
                n_vec++; if (bidx !== 3'd0)  begin n_err++; $display("FAIL reset_idx got %0d want 0", bidx); end
                n_vec++; if (bd !== '0)      begin n_err++; $display("FAIL reset_data got %h want 0", bd); end
            end
        end
    endtask

    task automatic test_lsb_basic();
        words_t w;
        logic   vb, va;
        int     tbl [8] = '{1, 2, 4, 0, 0, 0, 0, 8};
        do_reset();
        w = rand_words();
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h04; w[3] = 8'h80;
        fork
            begin send_packet(w, 3, 1'b0, 1'b1); vb = bv; @(negedge clk); wv = 1'b0; va = bv; end
            collect(8, 0);
        join
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL lsb_timeout got %b want 0", timed_out); end
        n_vec++; if (vb !== 1'b0) begin n_err++; $display("FAIL lsb_vld_early got %b want 0", vb); end
        n_vec++; if (va !== 1'b1) begin n_err++; $display("FAIL lsb_vld_latency got %b want 1", va); end
        n_vec++; if (obs_data.size() !== 8) begin n_err++; $display("FAIL lsb_count got %0d want 8", obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 8; k++) begin
            n_vec++; if (obs_data[k] !== MAXC'(tbl[k])) begin n_err++; $display("FAIL lsb_data[%0d] got %h want %h", k, obs_data[k], MAXC'(tbl[k])); end
            n_vec++; if (obs_idx[k] !== 3'(k)) begin n_err++; $display("FAIL lsb_idx[%0d] got %0d want %0d", k, obs_idx[k], k); end
            n_vec++; if (obs_last[k] !== (k == 7)) begin n_err++; $display("FAIL lsb_last[%0d] got %b want %b", k, obs_last[k], k == 7); end
        end
        n_vec++; if (obs_pulse.size() !== 1 || obs_pulse[0] !== 1'b1) begin n_err++; $display("FAIL lsb_pulse got %0d entries want one high", obs_pulse.size()); end
        n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL lsb_spurious got %0d want 0", spurious); end
    endtask

    task automatic test_msb_stall();
        words_t w;
        int     tbl [8] = '{8, 0, 0, 0, 0, 4, 2, 1};
        do_reset();
        w = rand_words();
        w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h04; w[3] = 8'h80;
        fork
            begin send_packet(w, 3, 1'b1, 1'b1); @(negedge clk); wv = 1'b0; end
            collect(8, 1);
        join
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL msb_timeout got %b want 0", timed_out); end
        n_vec++; if (obs_data.size() !== 8) begin n_err++; $display("FAIL msb_count got %0d want 8", obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 8; k++) begin
            n_vec++; if (obs_data[k] !== MAXC'(tbl[k])) begin n_err++; $display("FAIL msb_data[%0d] got %h want %h", k, obs_data[k], MAXC'(tbl[k])); end
            n_vec++; if (obs_idx[k] !== 3'(7 - k)) begin n_err++; $display("FAIL msb_idx[%0d] got %0d want %0d", k, obs_idx[k], 7 - k); end
            n_vec++; if (obs_last[k] !== (k == 7)) begin n_err++; $display("FAIL msb_last[%0d] got %b want %b", k, obs_last[k], k == 7); end
        end
        n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL msb_hold got %0d violations want 0", stall_err); end
        n_vec++; if (obs_pulse.size() !== 1 || obs_pulse[0] !== 1'b1) begin n_err++; $display("FAIL msb_pulse got %0d entries want one high", obs_pulse.size()); end
    endtask

    task automatic test_back_to_back();
        words_t w0, w1;
        int     want_stalls;
`ifdef WORD2BIT_PINGPONG_EN
        want_stalls = 0;
`else
        want_stalls = 8;
`endif
        do_reset();
        w0 = rand_words(); w1 = rand_words();
        exp_w.push_back(w0); exp_chn.push_back(127); exp_msb.push_back(1'b0);
        exp_w.push_back(w1); exp_chn.push_back(127); exp_msb.push_back(1'b1);
        fork
            begin send_packet(w0, 127, 1'b0, 1'b0); send_packet(w1, 127, 1'b1, 1'b0); @(negedge clk); wv = 1'b0; end
            collect(16, 0);
        join
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL b2b_timeout got %b want 0", timed_out); end
        n_vec++; if (in_stalls !== want_stalls) begin n_err++; $display("FAIL b2b_in_stalls got %0d want %0d", in_stalls, want_stalls); end
        n_vec++; if (obs_data.size() !== 16) begin n_err++; $display("FAIL b2b_count got %0d want 16", obs_data.size()); end
        for (int j = 0; j < obs_data.size() && j < 16; j++) begin
            n_vec++;
            if (obs_data[j] !== model_plane(exp_w[j / 8], exp_chn[j / 8], exp_msb[j / 8], j % 8)) begin
                n_err++; $display("FAIL b2b_data[%0d] got %h want %h", j, obs_data[j], model_plane(exp_w[j / 8], exp_chn[j / 8], exp_msb[j / 8], j % 8));
            end
        end
        n_vec++; if (obs_pulse.size() !== 2) begin n_err++; $display("FAIL b2b_pulses got %0d want 2", obs_pulse.size()); end
        n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL b2b_spurious got %0d want 0", spurious); end
    endtask

    task automatic test_random();
        int     np;
        int     c;
        words_t w;
        np = 6;
        do_reset();
        for (int p = 0; p < np; p++) begin
            c = (p == 0) ? 0 : (p == 1) ? 127 : int'($urandom_range(0, 127));
            exp_w.push_back(rand_words()); exp_chn.push_back(c); exp_msb.push_back(1'($urandom));
        end
        fork
            begin
                for (int p = 0; p < np; p++) begin
                    w = exp_w[p];
                    send_packet(w, exp_chn[p], exp_msb[p], 1'b1);
                end
                @(negedge clk); wv = 1'b0;
            end
            collect(np * 8, 2);
        join
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL rnd_timeout got %b want 0", timed_out); end
        n_vec++; if (obs_data.size() !== np * 8) begin n_err++; $display("FAIL rnd_count got %0d want %0d", obs_data.size(), np * 8); end
        for (int j = 0; j < obs_data.size() && j < np * 8; j++) begin
            n_vec++;
            if (obs_data[j] !== model_plane(exp_w[j / 8], exp_chn[j / 8], exp_msb[j / 8], j % 8)) begin
                n_err++; $display("FAIL rnd_data[%0d] got %h want %h", j, obs_data[j], model_plane(exp_w[j / 8], exp_chn[j / 8], exp_msb[j / 8], j % 8));
            end
            n_vec++;
            if (obs_idx[j] !== 3'(exp_msb[j / 8] ? 7 - (j % 8) : j % 8)) begin
                n_err++; $display("FAIL rnd_idx[%0d] got %0d want %0d", j, obs_idx[j], exp_msb[j / 8] ? 7 - (j % 8) : j % 8);
            end
            n_vec++; if (obs_last[j] !== ((j % 8) == 7)) begin n_err++; $display("FAIL rnd_last[%0d] got %b want %b", j, obs_last[j], (j % 8) == 7); end
        end
        n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL rnd_hold got %0d violations want 0", stall_err); end
        n_vec++; if (obs_pulse.size() !== np) begin n_err++; $display("FAIL rnd_pulses got %0d want %0d", obs_pulse.size(), np); end
        n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL rnd_spurious got %0d want 0", spurious); end
    endtask

    task automatic test_flush();
        words_t w;
        int     pc0;
        do_reset();
        send_packet(rand_words(), 3, 1'b0, 1'b0);
`ifdef WORD2BIT_PINGPONG_EN
        send_packet(rand_words(), 3, 1'b1, 1'b0);
`endif
        @(negedge clk); wv = 1'b0; br = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (bv !== 1'b1 || bidx !== 3'd3) begin n_err++; $display("FAIL flush_pre got vld=%b idx=%0d want vld=1 idx=3", bv, bidx); end
        pc0 = pulse_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; br = 1'b0;
        n_vec++; if (bv !== 1'b0)   begin n_err++; $display("FAIL flush_vld got %b want 0", bv); end
        n_vec++; if (wr_o !== 1'b1) begin n_err++; $display("FAIL flush_rdy got %b want 1", wr_o); end
        n_vec++; if (bd !== '0)     begin n_err++; $display("FAIL flush_data got %h want 0", bd); end
        br = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++; if (bv !== 1'b0) begin n_err++; $display("FAIL flush_quiet_vld c=%0d got %b want 0", c, bv); end
        end
        n_vec++; if (pulse_cnt !== pc0) begin n_err++; $display("FAIL flush_pulse got %0d pulses want 0", pulse_cnt - pc0); end
        br = 1'b0;
        // A word offered together with flush must not start a packet.
        @(negedge clk);
        flush = 1'b1; wv = 1'b1; wd = 8'h00; chn_i = 7'd0; msb_i = 1'b0;
        @(negedge clk);
        flush = 1'b0; wv = 1'b0;
        w = '0; w[0] = 8'hFF;
        fork
            begin send_packet(w, 0, 1'b0, 1'b0); @(negedge clk); wv = 1'b0; end
            collect(8, 0);
        join
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL flush_timeout got %b want 0", timed_out); end
        n_vec++; if (obs_data.size() !== 8) begin n_err++; $display("FAIL flush_count got %0d want 8", obs_data.size()); end
        for (int k = 0; k < obs_data.size() && k < 8; k++) begin
            n_vec++; if (obs_data[k] !== MAXC'(1)) begin n_err++; $display("FAIL flush_data[%0d] got %h want 1", k, obs_data[k]); end
            n_vec++; if (obs_idx[k] !== 3'(k)) begin n_err++; $display("FAIL flush_idx[%0d] got %0d want %0d", k, obs_idx[k], k); end
        end
        n_vec++; if (obs_pulse.size() !== 1 || obs_pulse[0] !== 1'b1) begin n_err++; $display("FAIL flush_final_pulse got %0d entries want one high", obs_pulse.size()); end
    endtask

    initial begin
        rst = 1'b1; wv = 1'b0; wd = '0; chn_i = '0; msb_i = 1'b0; flush = 1'b0; br = 1'b0;
        stall_err = 0; spurious = 0; in_stalls = 0; timed_out = 1'b0;
        test_reset();
        test_back_to_back();
        test_lsb_basic();
        test_msb_stall();
        test_random();
        test_flush();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
